fetch_instr_queue: RTL and testbench
====================================

Name: fetch_instr_queue

Overview:
- Circular instruction buffer between instruction fetch and the decode stage. Decode classifies instructions by opcode.
- Fetch writes up to SUPER_SCALAR_WIDTH instructions (with PCs) per cycle; decode reads up to SUPER_SCALAR_WIDTH in program order per cycle.
- Absorbs fetch/decode rate mismatch and back-pressure.
- Discards all contents on a pipeline flush (branch mispredict, exception redirect).

Parameters:
- DEPTH, 16, number of entries. Must be a power of two and ≥ 2*SUPER_SCALAR_WIDTH.
- SUPER_SCALAR_WIDTH, 2, lanes per cycle on each side. Taken from op_pkg.
- INSTRUCTION_WIDTH, 32, instruction bits. Taken from op_pkg.
- PC_WIDTH, 64, program-counter bits.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; asynchronous, active-high.
- flush_in  input  1  discard all entries.
- enq_valid_in  input  SUPER_SCALAR_WIDTH  per-lane valid from fetch; lane 0 is oldest.
- enq_instr_in  input  SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH  instructions; lane i occupies bits [i*32 +: 32].
- enq_pc_in  input  SUPER_SCALAR_WIDTH*PC_WIDTH  PC per lane.
- enq_ready_out  output  1  queue can accept a full SUPER_SCALAR_WIDTH group this cycle.
- deq_valid_out  output  SUPER_SCALAR_WIDTH  per-lane entry present; lane 0 is head.
- deq_instr_out  output  SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH  head instructions.
- deq_pc_out  output  SUPER_SCALAR_WIDTH*PC_WIDTH  head PCs.
- deq_ready_in  input  SUPER_SCALAR_WIDTH  per-lane accept from decode.
- count_out  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State: storage array, head_ptr, tail_ptr ($clog2(DEPTH) bits each, wrap modulo DEPTH), count register.
- Reset (async assert, rst_in=1):
  - head_ptr=0, tail_ptr=0, count=0.
  - deq_valid_out=0, count_out=0, enq_ready_out=1.
  - Storage contents are don't-care.
- enq_ready_out = (count ≤ DEPTH − SUPER_SCALAR_WIDTH).
  - Computed from registered count only; same-cycle dequeues are not credited.
  - Acceptance is all-or-nothing per cycle.
- Enqueue count n_enq:
  - Length of the contiguous run of 1s in enq_valid_in starting at lane 0.
  - Lanes after the first 0 are ignored, so 2'b10 enqueues nothing.
  - n_enq is forced to 0 when enq_ready_out=0.
  - Lane i is written to storage[tail_ptr+i].
  - tail_ptr advances by n_enq.
- Dequeue outputs (combinational from registered state, no enqueue bypass):
  - deq_valid_out[i] = (i < count).
  - deq_instr_out/deq_pc_out lane i = storage[head_ptr+i].
  - When deq_valid_out[i]=0, that lane's data is don't-care.
- Dequeue count n_deq:
  - Contiguous prefix of lanes with deq_valid_out[i] & deq_ready_in[i].
  - head_ptr advances by n_deq.
  - A lane with ready=1 after a non-ready lane is ignored.
- Latency:
  - An entry written in cycle N is visible on deq_valid_out in cycle N+1.
  - Minimum fetch-to-decode latency is 1 cycle.
- Simultaneous enqueue and dequeue: count_next = count + n_enq − n_deq. Both take effect in the same cycle.
- Full: count == DEPTH. enq_ready_out=0 whenever count > DEPTH−2 (i.e. at 15 or 16 with DEPTH=16).
- Empty: deq_valid_out=0, and deq_ready_in has no effect.
- Wrap-around:
  - Pointer arithmetic wraps naturally modulo DEPTH.
  - A group may straddle index DEPTH−1 → 0.
- Flush:
  - flush_in=1 at a clock edge sets head_ptr=tail_ptr=0 and count=0.
  - Same-cycle enqueue and dequeue are both cancelled.
  - flush_in takes priority over everything except reset.
  - Outputs reflect the empty state in the following cycle.
- Reset mid-operation: immediate return to reset state regardless of in-flight handshakes.
- Assertions (bench, not RTL):
  - count never exceeds DEPTH.
  - enq_valid_in is contiguous when enq_ready_out=1.

Decomposition:
- op_pkg gains:
  - typedef fetch_entry_t: struct packed { logic [INSTRUCTION_WIDTH-1:0] instr; logic [PC_WIDTH-1:0] pc; }.
  - localparam FIQ_DEPTH = 16.
- Parameters default from op_pkg.
- A single flat module; no sub-module is warranted.
- The prefix-count logic (shared by enqueue and dequeue) is a package function popcount_prefix(logic [SUPER_SCALAR_WIDTH-1:0]).

Test Plan:
- Reset then idle:
  - Response: deq_valid_out=2'b00, enq_ready_out=1, count_out=0.
  - Asserting rst_in mid-stream with 5 entries gives count_out=0 immediately.
- Fill/drain:
  - Stimulus: enqueue 8 pairs (PC 0x1000, 0x1004, …) with deq_ready_in=0.
  - Response: count_out=16, enq_ready_out=0.
  - Then deq_ready_in=2'b11: PCs emerge in order, 2 per cycle, for 8 cycles.
- Partial lanes:
  - enq_valid_in=2'b01 → count +1.
  - enq_valid_in=2'b10 → count unchanged.
  - With 1 entry and deq_ready_in=2'b11: only lane 0 valid, count→0.
- Simultaneous + wrap:
  - Preload 14 entries; keep enqueueing 2 and dequeueing 2 for 20 cycles.
  - Response: count stays 14; tail wraps past index 15; data order preserved.
  - An enqueue offered at count=15 is refused.
- Flush:
  - Stimulus: 6 entries, flush_in=1 together with enq_valid_in=2'b11 and deq_ready_in=2'b11.
  - Response: next cycle count_out=0 and deq_valid_out=0; flushed enqueue data never appears.
- Ready ordering: deq_ready_in=2'b10 with 4 entries → no dequeue, count stays 4.

Source files
------------

// File: rtl/op_pkg.sv
// ---------------------------------------------------------------------------
// op_pkg
// Shared pipeline-wide definitions for the front end.
//   SUPER_SCALAR_WIDTH : lanes per cycle on fetch and decode sides
//   INSTRUCTION_WIDTH  : bits per instruction word
//   PC_WIDTH           : program-counter bits
//   FIQ_DEPTH          : default depth of the fetch instruction queue
//   fetch_entry_t      : one queued instruction together with its PC
//   popcount_prefix()  : length of the run of 1s starting at lane 0
// ---------------------------------------------------------------------------
package op_pkg;

  localparam int SUPER_SCALAR_WIDTH = 2;
  localparam int INSTRUCTION_WIDTH  = 32;
  localparam int PC_WIDTH           = 64;
  localparam int FIQ_DEPTH          = 16;

  // Wide enough to hold any lane count 0..SUPER_SCALAR_WIDTH.
  localparam int LANE_CNT_W = $clog2(SUPER_SCALAR_WIDTH + 1);

  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]          pc;
  } fetch_entry_t;

  // Handshakes are in program order, so only the unbroken run of set bits
  // beginning at lane 0 counts; anything after the first clear bit is ignored.
  function automatic logic [LANE_CNT_W-1:0] popcount_prefix(
    input logic [SUPER_SCALAR_WIDTH-1:0] lanes
  );
    logic [LANE_CNT_W-1:0] n;
    logic                  run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      run = run & lanes[i];
      if (run) n = LANE_CNT_W'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_instr_queue.sv
// ---------------------------------------------------------------------------
// fetch_instr_queue
// Circular buffer decoupling instruction fetch from decode. Fetch pushes up
// to SUPER_SCALAR_WIDTH instructions per cycle, decode pops up to
// SUPER_SCALAR_WIDTH per cycle in program order, and a flush empties it.
//
// Ports:
//   clk_in         clock
//   rst_in         asynchronous active-high reset
//   flush_in       discard all entries (cancels same-cycle enq/deq)
//   enq_valid_in   per-lane valid from fetch, lane 0 oldest
//   enq_instr_in   per-lane instruction words
//   enq_pc_in      per-lane PCs
//   enq_ready_out  room for a full group this cycle
//   deq_valid_out  per-lane entry present, lane 0 is head
//   deq_instr_out  head instruction words
//   deq_pc_out     head PCs
//   deq_ready_in   per-lane accept from decode
//   count_out      current occupancy
// ---------------------------------------------------------------------------
module fetch_instr_queue #(
  parameter int DEPTH              = op_pkg::FIQ_DEPTH,
  parameter int SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
  parameter int INSTRUCTION_WIDTH  = op_pkg::INSTRUCTION_WIDTH,
  parameter int PC_WIDTH           = op_pkg::PC_WIDTH
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          flush_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]                 enq_valid_in,
  input  logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] enq_instr_in,
  input  logic [SUPER_SCALAR_WIDTH*PC_WIDTH-1:0]        enq_pc_in,
  output logic                                          enq_ready_out,
  output logic [SUPER_SCALAR_WIDTH-1:0]                 deq_valid_out,
  output logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] deq_instr_out,
  output logic [SUPER_SCALAR_WIDTH*PC_WIDTH-1:0]        deq_pc_out,
  input  logic [SUPER_SCALAR_WIDTH-1:0]                 deq_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]                    count_out
);

  import op_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       head_ptr;
  logic [PTR_W-1:0]       tail_ptr;
  logic [CNT_W-1:0]       count;
  logic [LANE_CNT_W-1:0]  n_enq;
  logic [LANE_CNT_W-1:0]  n_deq;
  logic                   enq_ready;
  logic [SUPER_SCALAR_WIDTH-1:0] deq_valid;

  // Readiness looks only at the registered count so that fetch never sees a
  // combinational path from decode's ready; a full group must always fit.
  assign enq_ready = (count <= CNT_W'(DEPTH - SUPER_SCALAR_WIDTH));
  assign n_enq     = enq_ready ? popcount_prefix(enq_valid_in) : '0;
  assign n_deq     = popcount_prefix(deq_valid & deq_ready_in);

  // Head lanes read straight from storage; pointer addition wraps modulo
  // DEPTH, so a group straddling the last index needs no special case.
  genvar g;
  for (g = 0; g < SUPER_SCALAR_WIDTH; g++) begin : g_lane
    assign deq_valid[g] = (CNT_W'(g) < count);
    assign deq_instr_out[g*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] =
      mem[head_ptr + PTR_W'(g)].instr;
    assign deq_pc_out[g*PC_WIDTH +: PC_WIDTH] =
      mem[head_ptr + PTR_W'(g)].pc;
  end

  assign deq_valid_out = deq_valid;
  assign enq_ready_out = enq_ready;
  assign count_out     = count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      head_ptr <= head_ptr + PTR_W'(n_deq);
      tail_ptr <= tail_ptr + PTR_W'(n_enq);
      count    <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

  // Storage carries no reset; entries outside the head..tail window are
  // never observed because deq_valid masks them.
  always_ff @(posedge clk_in) begin
    if (!flush_in) begin
      for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
        if (LANE_CNT_W'(i) < n_enq) begin
          mem[tail_ptr + PTR_W'(i)] <= '{
            instr: enq_instr_in[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH],
            pc:    enq_pc_in[i*PC_WIDTH +: PC_WIDTH]
          };
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_instr_queue
// Self-checking bench for fetch_instr_queue: a queue-based reference model
// is compared against the DUT every cycle, and directed scenarios pin key
// values with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_fetch_instr_queue;

  localparam int SSW   = 2;
  localparam int IW    = 32;
  localparam int PW    = 64;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  typedef struct {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic [SSW-1:0]    enq_valid = '0;
  logic [SSW*IW-1:0] enq_instr = '0;
  logic [SSW*PW-1:0] enq_pc = '0;
  logic              enq_ready;
  logic [SSW-1:0]    deq_valid;
  logic [SSW*IW-1:0] deq_instr;
  logic [SSW*PW-1:0] deq_pc;
  logic [SSW-1:0]    deq_ready = '0;
  logic [CW-1:0]     count;

  int        n_cmp = 0;
  int        n_bad = 0;
  bit        started = 1'b0;
  logic [PW-1:0] next_pc = 64'h1000;
  ent_t      model_q[$];

  fetch_instr_queue dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .flush_in      (flush),
    .enq_valid_in  (enq_valid),
    .enq_instr_in  (enq_instr),
    .enq_pc_in     (enq_pc),
    .enq_ready_out (enq_ready),
    .deq_valid_out (deq_valid),
    .deq_instr_out (deq_instr),
    .deq_pc_out    (deq_pc),
    .deq_ready_in  (deq_ready),
    .count_out     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Number of leading consecutive set lanes, counted by hand.
  function automatic int leading_ones(input logic [SSW-1:0] v);
    int k = 0;
    while (k < SSW && v[k] == 1'b1) k++;
    return k;
  endfunction

  // Reference model: a plain FIFO of entries, updated at each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      int  n_d;
      int  n_e;
      bit  room;
      room = (model_q.size() + SSW <= DEPTH);
      n_d  = leading_ones(deq_ready);
      if (n_d > model_q.size()) n_d = model_q.size();
      n_e  = room ? leading_ones(enq_valid) : 0;
      if (room && enq_valid != '0 && n_e == 0)
        $display("[TB] note: non-contiguous enq_valid %b offered", enq_valid);
      for (int i = 0; i < n_d; i++) void'(model_q.pop_front());
      for (int i = 0; i < n_e; i++) begin
        ent_t e;
        e.instr = enq_instr[i*IW +: IW];
        e.pc    = enq_pc[i*PW +: PW];
        model_q.push_back(e);
      end
    end
  end

  // Per-cycle comparison of all registered-state outputs against the model.
  always @(negedge clk) begin
    if (started && !rst) begin
      int sz;
      logic [SSW-1:0] exp_valid;
      sz = model_q.size();
      for (int i = 0; i < SSW; i++) exp_valid[i] = (i < sz);
      check("model_count", 64'(count), 64'(sz));
      check("model_valid", 64'(deq_valid), 64'(exp_valid));
      check("model_ready", 64'(enq_ready), 64'(sz <= DEPTH - SSW));
      if (count > CW'(DEPTH)) check("count_bound", 64'(count), 64'(DEPTH));
      for (int i = 0; i < SSW; i++) begin
        if (i < sz) begin
          check("model_pc", deq_pc[i*PW +: PW], model_q[i].pc);
          check("model_instr", 64'(deq_instr[i*IW +: IW]), 64'(model_q[i].instr));
        end
      end
    end
  end

  // One cycle of stimulus: inputs applied at the falling edge, held across
  // the rising edge, then returned to idle.
  task automatic applyStimulus(input logic [SSW-1:0] ev, input logic [SSW-1:0] dr, input logic fl);
    @(negedge clk);
    enq_valid = ev;
    deq_ready = dr;
    flush     = fl;
    for (int i = 0; i < SSW; i++) begin
      logic [PW-1:0] p;
      p = next_pc + 64'(4 * i);
      enq_pc[i*PW +: PW]    = p;
      enq_instr[i*IW +: IW] = 32'hA500_0000 ^ p[31:0];
    end
    @(posedge clk);
    #1;
    next_pc   = next_pc + 64'(4 * SSW);
    enq_valid = '0;
    deq_ready = '0;
    flush     = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check(name, act, exp);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    doReset();
    started = 1'b1;
    @(negedge clk);
    checkOutput("reset_valid", 64'(deq_valid), 64'h0);
    checkOutput("reset_ready", 64'(enq_ready), 64'h1);
    checkOutput("reset_count", 64'(count), 64'h0);

    // Fill to full with consecutive PCs, then drain in order.
    next_pc = 64'h1000;
    for (int k = 0; k < 8; k++) applyStimulus(2'b11, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("fill_count", 64'(count), 64'd16);
    checkOutput("fill_ready", 64'(enq_ready), 64'h0);
    checkOutput("fill_head_pc0", deq_pc[0 +: PW], 64'h1000);
    checkOutput("fill_head_pc1", deq_pc[PW +: PW], 64'h1004);
    checkOutput("fill_head_instr0", 64'(deq_instr[0 +: IW]), 64'hA500_1000);
    applyStimulus(2'b11, 2'b11, 1'b0);
    @(negedge clk);
    checkOutput("drain_pc0", deq_pc[0 +: PW], 64'h1008);
    checkOutput("drain_count", 64'(count), 64'd14);
    for (int k = 0; k < 7; k++) applyStimulus(2'b00, 2'b11, 1'b0);
    @(negedge clk);
    checkOutput("drained_count", 64'(count), 64'd0);

    // Partial lane patterns.
    applyStimulus(2'b01, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("partial_01", 64'(count), 64'd1);
    applyStimulus(2'b10, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("partial_10", 64'(count), 64'd1);
    checkOutput("partial_valid", 64'(deq_valid), 64'h1);
    applyStimulus(2'b00, 2'b11, 1'b0);
    @(negedge clk);
    checkOutput("partial_drain", 64'(count), 64'd0);

    // Ready ordering: lane 1 ready alone does nothing.
    applyStimulus(2'b11, 2'b00, 1'b0);
    applyStimulus(2'b11, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b10, 1'b0);
    @(negedge clk);
    checkOutput("ready_order", 64'(count), 64'd4);

    // Reset in the middle of traffic with five entries held.
    applyStimulus(2'b01, 2'b00, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_count", 64'(count), 64'd0);
    checkOutput("midreset_valid", 64'(deq_valid), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Preload 14, then steady enqueue/dequeue across the wrap point.
    for (int k = 0; k < 7; k++) applyStimulus(2'b11, 2'b00, 1'b0);
    for (int k = 0; k < 20; k++) applyStimulus(2'b11, 2'b11, 1'b0);
    @(negedge clk);
    checkOutput("steady_count", 64'(count), 64'd14);
    applyStimulus(2'b01, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("at15_ready", 64'(enq_ready), 64'h0);
    applyStimulus(2'b11, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("at15_refused", 64'(count), 64'd15);

    // Flush together with enqueue and dequeue.
    applyStimulus(2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(2'b11, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("preflush_count", 64'(count), 64'd6);
    applyStimulus(2'b11, 2'b11, 1'b1);
    @(negedge clk);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_valid", 64'(deq_valid), 64'h0);
    next_pc = 64'h8000;
    applyStimulus(2'b01, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("postflush_pc", deq_pc[0 +: PW], 64'h8000);
    checkOutput("postflush_count", 64'(count), 64'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
